// File: rtl/calc_result_display.sv
// Binary-to-BCD conversion (shift-add-3) of the adder/subtractor result, driven onto a 4-digit muxed 7-seg display.
// Latency: bcd/neg update 8 cycles after start is sampled, done pulses the following cycle; seg/an lag scan counter by 1.
// Backpressure: none; start is sampled only in IDLE and dropped while busy. Optional macro: CALC_SIGNED_DISPLAY_EN.
module calc_result_display #(
  parameter int REFRESH_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  value,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd,
  output logic        neg,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  state_t      state, state_nxt;
  logic        load, last;
  logic [7:0]  mag, mag_in, mag_nxt;
  logic [11:0] scratch, scratch_nxt, adj;
  logic [2:0]  cnt;
  logic        unused_msb;

  logic [REFRESH_BITS-1:0] scan_cnt;
  logic [1:0]  sel;
  logic [3:0]  dig_h, dig_t, dig_o;
  logic [6:0]  seg_nxt;
  logic [3:0]  an_nxt;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

`ifdef CALC_SIGNED_DISPLAY_EN
  logic neg_pend;

  assign mag_in = value[7] ? (~value + 8'd1) : value;

  // Sign is captured at start but only published together with bcd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_pend <= 1'b0;
      neg      <= 1'b0;
    end else begin
      if (load) neg_pend <= value[7];
      if (last) neg      <= neg_pend;
    end
  end
`else
  assign mag_in = value;
  assign neg    = 1'b0;
`endif

  always_comb begin
    adj = scratch;
    for (int i = 0; i < 3; i++) begin
      if (scratch[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
    end
  end

  assign {unused_msb, scratch_nxt, mag_nxt} = {adj, mag, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    last      = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == 3'd7) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag     <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd     <= '0;
      done    <= 1'b0;
    end else begin
      if (load) begin
        mag     <= mag_in;
        scratch <= '0;
        cnt     <= '0;
      end else if (state == SHIFT) begin
        mag     <= mag_nxt;
        scratch <= scratch_nxt;
        cnt     <= cnt + 3'd1;
      end
      if (last) bcd <= scratch_nxt;
      done <= last;
    end
  end

  assign sel   = scan_cnt[REFRESH_BITS-1 -: 2];
  assign dig_h = bcd[11:8];
  assign dig_t = bcd[7:4];
  assign dig_o = bcd[3:0];

  // Digit select with leading-zero blanking; ones is always lit.
  always_comb begin
    an_nxt  = 4'b1110;
    seg_nxt = seg7(dig_o);
    case (sel)
      2'd1: begin
        an_nxt  = 4'b1101;
        seg_nxt = (dig_h == 4'd0 && dig_t == 4'd0) ? SEG_BLANK : seg7(dig_t);
      end
      2'd2: begin
        an_nxt  = 4'b1011;
        seg_nxt = (dig_h == 4'd0) ? SEG_BLANK : seg7(dig_h);
      end
      2'd3: begin
        an_nxt  = 4'b0111;
        seg_nxt = neg ? SEG_DASH : SEG_BLANK;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      an       <= 4'b1110;
      seg      <= 7'b1000000;
    end else begin
      scan_cnt <= scan_cnt + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
      an       <= an_nxt;
      seg      <= seg_nxt;
    end
  end

endmodule

// File: doc/calc_result_display.md
# calc_result_display

Sequential output stage of the calculator. It takes the 8-bit result word from the 4-bit adder/subtractor and converts it from binary to three BCD digits with a shift-add-3 (double-dabble) engine. It then drives the result onto a 4-digit multiplexed seven-segment display. The block is the consumer end of the `addsub` result bus.

## Interface
- `REFRESH_BITS`, default 16: width of the free-running scan counter; each digit is active for 2^(REFRESH_BITS-2) cycles.
- `clk` in 1: single system clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: request to convert `value`; sampled only in IDLE.
- `value` in 8: result word from the adder/subtractor.
- `busy` out 1: high while the conversion runs.
- `done` out 1: one-cycle pulse when `bcd` has been updated.
- `bcd` out 12: registered result, hundreds[11:8], tens[7:4], ones[3:0].
- `neg` out 1: registered sign of the last result; always 0 without the macro.
- `seg` out 7: segments, active-low, bit order g,f,e,d,c,b,a (bit 6 = g).
- `an` out 4: digit enables, active-low, bit 0 = ones digit.

## Operation
- FSM states:
  - IDLE: `start`=1 loads the magnitude register from `value`, clears the 12-bit scratch register and the shift count, then moves to SHIFT.
  - SHIFT: each cycle, every scratch nibble ≥5 gets +3. The {scratch, magnitude} pair then shifts left by 1, and the count increments.
  - After the 8th shift, the FSM registers the scratch value into `bcd`, sets `done`, and returns to IDLE.
- Arithmetic:
  - Magnitude is 8 bits unsigned; the maximum is 255, giving `bcd`=12'h255.
  - The add-3 step is a 4-bit add with no carry out, because the operand is ≤9 after correction.
- `start` while busy is ignored (not queued). `start` in the cycle `done` is high is accepted, because the FSM is already in IDLE.
- `bcd` and `neg` hold the previous result for the whole conversion, so the display never shows partial values.
- Scanner:
  - The REFRESH_BITS counter runs freely and wraps.
  - Its top 2 bits select the digit: 0 = ones, 1 = tens, 2 = hundreds, 3 = sign.
  - Exactly one `an` bit is low at any time.
- Leading-zero blanking:
  - Hundreds is blank when 0.
  - Tens is blank when hundreds and tens are both 0.
  - Ones is always shown.
  - Sign digit is blank unless `neg`=1, in which case it shows '-'.
- Segment codes:
  - Digits: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Blank = 1111111; '-' = 0111111.
  - A nibble >9 (unreachable) shows blank.

## Timing
- Reset values:
  - FSM in IDLE; `busy`=0, `done`=0, `bcd`=0, `neg`=0.
  - Scan counter = 0, so `an`=4'b1110 and `seg`=7'b1000000 ('0').
- Latency, with `start` sampled at edge N:
  - `busy`=1 from after edge N until edge N+8: exactly 8 cycles.
  - Shifts occur at edges N+1 through N+8.
  - `bcd`/`neg` update at edge N+8; `done`=1 for exactly the one cycle after edge N+8.
  - `busy` and `done` are never high together.
- `seg`/`an` are registered. They follow the scan counter and `bcd` with 1 cycle of latency.
- Reset asserted mid-conversion: immediate return to IDLE and all reset values, with no `done`. After `rst_n` deasserts, the next conversion behaves normally.

## Configuration
- `CALC_SIGNED_DISPLAY_EN` defined:
  - `value` is treated as two's complement.
  - In IDLE, `start` captures `neg`=`value`[7] and magnitude = |`value|`. 8'h80 gives magnitude 128.
  - `neg` is registered alongside `bcd`; the sign digit shows '-' when `neg`=1.
- `CALC_SIGNED_DISPLAY_EN` undefined:
  - `value` is unsigned 0..255, and `neg` is tied to 0.
  - The sign digit is always blank.

## Test plan
- Reset release with no stimulus -> `busy`=0, `done`=0, `bcd`=0, `an`=1110, `seg`=1000000.
- `start` with `value`=8'd255 (unsigned build) -> `busy` high for 8 cycles; `done` pulses 1 cycle after edge N+8; `bcd`=12'h255. The scan then shows 5, 5, 2, blank on `an`=1110, 1101, 1011, 0111.
- `value`=8'd7 -> `bcd`=12'h007; hundreds and tens blank, ones shows 1111000.
- Signed build, `value`=8'hF6 -> `neg`=1, `bcd`=12'h010; sign digit shows 0111111. `value`=8'h80 -> `bcd`=12'h128, `neg`=1.
- `start` pulsed again 3 cycles into a conversion -> ignored; single `done`, and `bcd` reflects the first `value`. `start` held high -> back-to-back conversions with `done` every 9 cycles.
- `rst_n` pulled low at shift 4 -> immediate reset values, no `done`. With `REFRESH_BITS`=4, `an` cycles 1110→1101→1011→0111 every 4 cycles and wraps.
